// File: rtl/cci_mpf_engine_mux_pkg.sv
// Shared types and Mdata packing helpers for the MPF engine mux.
// Mdata layout: engine index in the top ENG_W bits, zero pad, engine tag in the low bits.
package cci_mpf_engine_mux_pkg;

  localparam int MDATA_W = 16;

  typedef logic [3:0]         t_eng_idx;
  typedef logic [MDATA_W-1:0] t_eng_tag;

  function automatic int eng_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MDATA_W-1:0] mdata_pack(input t_eng_idx idx, input t_eng_tag tag,
                                                    input int ew, input int tw);
    logic [31:0] m;
    m = ({16'b0, tag} & ((32'd1 << tw) - 32'd1)) | ({28'b0, idx} << (MDATA_W - ew));
    return m[MDATA_W-1:0];
  endfunction

  function automatic t_eng_idx mdata_idx(input logic [MDATA_W-1:0] md, input int ew);
    logic [MDATA_W-1:0] s;
    s = md >> (MDATA_W - ew);
    return s[3:0];
  endfunction

  function automatic t_eng_tag mdata_tag(input logic [MDATA_W-1:0] md, input int tw);
    logic [31:0] m;
    m = {16'b0, md} & ((32'd1 << tw) - 32'd1);
    return m[MDATA_W-1:0];
  endfunction

endpackage

// File: rtl/cci_mpf_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus winner index; the pointer moves to winner+1.
module cci_mpf_rr_arbiter
  import cci_mpf_engine_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = eng_w(N)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] k;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr_q) + i) % N);
      if (!found && req_i[k]) begin
        found     = 1'b1;
        gnt_o[k]  = 1'b1;
        gnt_idx_o = k;
      end
    end
    ptr_d = ptr_q;
    if (found) ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + IW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cci_mpf_app_engine_mux.sv
// Shares one MPF CCI read/write request path among N_ENGINES engines with per-engine credit limits.
// Optional CCI_MPF_ENGINE_MUX_STATS_EN adds per-engine 32-bit grant counters.
module cci_mpf_app_engine_mux
  import cci_mpf_engine_mux_pkg::*;
#(
  parameter int N_ENGINES       = 4,
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 64,
  parameter int LINE_ADDR_W     = 42
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [N_ENGINES-1:0]                    eng_rd_valid_i,
  input  logic [N_ENGINES-1:0][LINE_ADDR_W-1:0]   eng_rd_addr_i,
  input  logic [N_ENGINES-1:0][TAG_W-1:0]         eng_rd_tag_i,
  output logic [N_ENGINES-1:0]                    eng_rd_ready_o,
  input  logic [N_ENGINES-1:0]                    eng_wr_valid_i,
  input  logic [N_ENGINES-1:0][LINE_ADDR_W-1:0]   eng_wr_addr_i,
  input  logic [N_ENGINES-1:0][511:0]             eng_wr_data_i,
  input  logic [N_ENGINES-1:0][TAG_W-1:0]         eng_wr_tag_i,
  output logic [N_ENGINES-1:0]                    eng_wr_ready_o,
  output logic [N_ENGINES-1:0]                    eng_rd_rsp_valid_o,
  output logic [511:0]                            eng_rd_rsp_data_o,
  output logic [TAG_W-1:0]                        eng_rd_rsp_tag_o,
  output logic [N_ENGINES-1:0]                    eng_wr_rsp_valid_o,
  output logic [TAG_W-1:0]                        eng_wr_rsp_tag_o,
  output logic                                    c0_req_valid_o,
  output logic [LINE_ADDR_W-1:0]                  c0_req_addr_o,
  output logic [15:0]                             c0_req_mdata_o,
  output logic                                    c1_req_valid_o,
  output logic [LINE_ADDR_W-1:0]                  c1_req_addr_o,
  output logic [511:0]                            c1_req_data_o,
  output logic [15:0]                             c1_req_mdata_o,
  input  logic                                    c0_alm_full_i,
  input  logic                                    c1_alm_full_i,
  input  logic                                    c0_rsp_valid_i,
  input  logic [511:0]                            c0_rsp_data_i,
  input  logic [15:0]                             c0_rsp_mdata_i,
  input  logic                                    c1_rsp_valid_i,
  input  logic [15:0]                             c1_rsp_mdata_i,
`ifdef CCI_MPF_ENGINE_MUX_STATS_EN
  output logic [N_ENGINES-1:0][31:0]              eng_stat_rd_o,
  output logic [N_ENGINES-1:0][31:0]              eng_stat_wr_o,
`endif
  output logic                                    mux_error_o
);

  localparam int ENG_W = eng_w(N_ENGINES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [N_ENGINES-1:0]            rd_req, wr_req, rd_gnt, wr_gnt, rd_hit, wr_hit;
  logic [ENG_W-1:0]                rd_idx, wr_idx;
  logic [N_ENGINES-1:0][CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                            rd_bad, wr_bad, mux_error_q, mux_error_d;
  t_eng_idx                        c0_idx, c1_idx;

  assign c0_idx = mdata_idx(c0_rsp_mdata_i, ENG_W);
  assign c1_idx = mdata_idx(c1_rsp_mdata_i, ENG_W);

  // Eligibility, response decode and credit bookkeeping; grant and response together cancel.
  always_comb begin
    rd_req   = '0;
    wr_req   = '0;
    rd_hit   = '0;
    wr_hit   = '0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    for (int i = 0; i < N_ENGINES; i++) begin
      rd_req[i] = eng_rd_valid_i[i] && (rd_cnt_q[i] < CNT_MAX) && !c0_alm_full_i && !reset_i;
      wr_req[i] = eng_wr_valid_i[i] && (wr_cnt_q[i] < CNT_MAX) && !c1_alm_full_i && !reset_i;
      rd_hit[i] = c0_rsp_valid_i && (c0_idx == t_eng_idx'(i)) && (rd_cnt_q[i] != '0);
      wr_hit[i] = c1_rsp_valid_i && (c1_idx == t_eng_idx'(i)) && (wr_cnt_q[i] != '0);
      case ({rd_gnt[i], rd_hit[i]})
        2'b10:   rd_cnt_d[i] = rd_cnt_q[i] + CNT_W'(1);
        2'b01:   rd_cnt_d[i] = rd_cnt_q[i] - CNT_W'(1);
        default: rd_cnt_d[i] = rd_cnt_q[i];
      endcase
      case ({wr_gnt[i], wr_hit[i]})
        2'b10:   wr_cnt_d[i] = wr_cnt_q[i] + CNT_W'(1);
        2'b01:   wr_cnt_d[i] = wr_cnt_q[i] - CNT_W'(1);
        default: wr_cnt_d[i] = wr_cnt_q[i];
      endcase
    end
  end

  assign rd_bad      = c0_rsp_valid_i && !(|rd_hit);
  assign wr_bad      = c1_rsp_valid_i && !(|wr_hit);
  assign mux_error_d = mux_error_q | rd_bad | wr_bad;

  cci_mpf_rr_arbiter #(.N(N_ENGINES)) u_rd_arb (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(rd_req), .gnt_o(rd_gnt), .gnt_idx_o(rd_idx));

  cci_mpf_rr_arbiter #(.N(N_ENGINES)) u_wr_arb (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(wr_req), .gnt_o(wr_gnt), .gnt_idx_o(wr_idx));

  assign eng_rd_ready_o = rd_gnt;
  assign eng_wr_ready_o = wr_gnt;
  assign mux_error_o    = mux_error_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      c0_req_valid_o     <= 1'b0;
      c1_req_valid_o     <= 1'b0;
      eng_rd_rsp_valid_o <= '0;
      eng_wr_rsp_valid_o <= '0;
      rd_cnt_q           <= '0;
      wr_cnt_q           <= '0;
      mux_error_q        <= 1'b0;
    end else begin
      c0_req_valid_o     <= |rd_gnt;
      c1_req_valid_o     <= |wr_gnt;
      eng_rd_rsp_valid_o <= rd_hit;
      eng_wr_rsp_valid_o <= wr_hit;
      rd_cnt_q           <= rd_cnt_d;
      wr_cnt_q           <= wr_cnt_d;
      mux_error_q        <= mux_error_d;
    end
  end

  // Payload registers carry no reset; the valids above qualify them.
  always_ff @(posedge clk_i) begin
    if (|rd_gnt) begin
      c0_req_addr_o  <= eng_rd_addr_i[rd_idx];
      c0_req_mdata_o <= mdata_pack(t_eng_idx'(rd_idx), t_eng_tag'(eng_rd_tag_i[rd_idx]), ENG_W, TAG_W);
    end
    if (|wr_gnt) begin
      c1_req_addr_o  <= eng_wr_addr_i[wr_idx];
      c1_req_data_o  <= eng_wr_data_i[wr_idx];
      c1_req_mdata_o <= mdata_pack(t_eng_idx'(wr_idx), t_eng_tag'(eng_wr_tag_i[wr_idx]), ENG_W, TAG_W);
    end
    if (c0_rsp_valid_i) begin
      eng_rd_rsp_data_o <= c0_rsp_data_i;
      eng_rd_rsp_tag_o  <= TAG_W'(mdata_tag(c0_rsp_mdata_i, TAG_W));
    end
    if (c1_rsp_valid_i) eng_wr_rsp_tag_o <= TAG_W'(mdata_tag(c1_rsp_mdata_i, TAG_W));
  end

`ifdef CCI_MPF_ENGINE_MUX_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      eng_stat_rd_o <= '0;
      eng_stat_wr_o <= '0;
    end else begin
      for (int i = 0; i < N_ENGINES; i++) begin
        if (rd_gnt[i]) eng_stat_rd_o[i] <= eng_stat_rd_o[i] + 32'd1;
        if (wr_gnt[i]) eng_stat_wr_o[i] <= eng_stat_wr_o[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_app_engine_mux.sv
// Bench for cci_mpf_app_engine_mux: vector table for arbitration plus hand sequences,
// with a cycle model feeding expected requests/responses through scoreboard queues.
module tb_cci_mpf_app_engine_mux;
  localparam int N = 4, TW = 8, MAXO = 64, AW = 42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic [N-1:0]            rd_v, wr_v, rd_rdy, wr_rdy, rrsp_v, wrsp_v;
  logic [N-1:0][AW-1:0]    rd_addr, wr_addr;
  logic [N-1:0][TW-1:0]    rd_tag, wr_tag;
  logic [N-1:0][511:0]     wr_data;
  logic [511:0]            rrsp_data, c1_data_o, c0_data;
  logic [TW-1:0]           rrsp_tag, wrsp_tag;
  logic                    c0_v_o, c1_v_o, c0_af, c1_af, c0_rv, c1_rv, err_o;
  logic [AW-1:0]           c0_addr_o, c1_addr_o;
  logic [15:0]             c0_md_o, c1_md_o, c0_md, c1_md;
`ifdef CCI_MPF_ENGINE_MUX_STATS_EN
  logic [N-1:0][31:0]      stat_rd, stat_wr;
`endif

  cci_mpf_app_engine_mux #(.N_ENGINES(N), .TAG_W(TW), .MAX_OUTSTANDING(MAXO), .LINE_ADDR_W(AW)) dut (
    .clk_i(clk), .reset_i(reset),
    .eng_rd_valid_i(rd_v), .eng_rd_addr_i(rd_addr), .eng_rd_tag_i(rd_tag), .eng_rd_ready_o(rd_rdy),
    .eng_wr_valid_i(wr_v), .eng_wr_addr_i(wr_addr), .eng_wr_data_i(wr_data), .eng_wr_tag_i(wr_tag),
    .eng_wr_ready_o(wr_rdy),
    .eng_rd_rsp_valid_o(rrsp_v), .eng_rd_rsp_data_o(rrsp_data), .eng_rd_rsp_tag_o(rrsp_tag),
    .eng_wr_rsp_valid_o(wrsp_v), .eng_wr_rsp_tag_o(wrsp_tag),
    .c0_req_valid_o(c0_v_o), .c0_req_addr_o(c0_addr_o), .c0_req_mdata_o(c0_md_o),
    .c1_req_valid_o(c1_v_o), .c1_req_addr_o(c1_addr_o), .c1_req_data_o(c1_data_o), .c1_req_mdata_o(c1_md_o),
    .c0_alm_full_i(c0_af), .c1_alm_full_i(c1_af),
    .c0_rsp_valid_i(c0_rv), .c0_rsp_data_i(c0_data), .c0_rsp_mdata_i(c0_md),
    .c1_rsp_valid_i(c1_rv), .c1_rsp_mdata_i(c1_md),
`ifdef CCI_MPF_ENGINE_MUX_STATS_EN
    .eng_stat_rd_o(stat_rd), .eng_stat_wr_o(stat_wr),
`endif
    .mux_error_o(err_o));

  typedef struct { logic v; logic [AW-1:0] addr; logic [15:0] md; logic [511:0] data; } req_t;
  typedef struct { logic [N-1:0] v; logic [TW-1:0] tag; logic [511:0] data; } rsp_t;
  typedef struct { logic [N-1:0] rd, wr; logic af0, af1; logic [N-1:0] exp_rd, exp_wr; } vec_t;

  req_t c0_q[$], c1_q[$];
  rsp_t rr_q[$], wr_q[$];
  int   total = 0, bad = 0;
  int   m_rd_ptr, m_wr_ptr;
  int   m_rd_cnt[N], m_wr_cnt[N];
  logic m_err;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k = (ptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  // One clock: predict grants/responses from current inputs, then score the registered outputs.
  task automatic tick();
    logic [N-1:0] el_r, el_w, exp_r, exp_w, rv, wv;
    int gr, gw, ir, iw;
    logic bad_r, bad_w;
    req_t e;
    rsp_t r;
    #1;
    el_r = '0; el_w = '0;
    for (int i = 0; i < N; i++) begin
      el_r[i] = rd_v[i] && (m_rd_cnt[i] < MAXO);
      el_w[i] = wr_v[i] && (m_wr_cnt[i] < MAXO);
    end
    gr = (reset || c0_af) ? -1 : pick(el_r, m_rd_ptr);
    gw = (reset || c1_af) ? -1 : pick(el_w, m_wr_ptr);
    exp_r = (gr >= 0) ? (N'(1) << gr) : '0;
    exp_w = (gw >= 0) ? (N'(1) << gw) : '0;
    check("rd_ready", rd_rdy, exp_r);
    check("wr_ready", wr_rdy, exp_w);
    e = '{v: 1'b0, addr: '0, md: '0, data: '0};
    if (gr >= 0) e = '{v: 1'b1, addr: rd_addr[gr], md: (16'(gr) << 14) | 16'(rd_tag[gr]), data: '0};
    c0_q.push_back(e);
    e = '{v: 1'b0, addr: '0, md: '0, data: '0};
    if (gw >= 0) e = '{v: 1'b1, addr: wr_addr[gw], md: (16'(gw) << 14) | 16'(wr_tag[gw]), data: wr_data[gw]};
    c1_q.push_back(e);
    ir = int'(c0_md[15:14]); iw = int'(c1_md[15:14]);
    rv = '0; wv = '0; bad_r = 1'b0; bad_w = 1'b0;
    if (!reset && c0_rv) begin
      if (m_rd_cnt[ir] > 0) rv[ir] = 1'b1; else bad_r = 1'b1;
    end
    if (!reset && c1_rv) begin
      if (m_wr_cnt[iw] > 0) wv[iw] = 1'b1; else bad_w = 1'b1;
    end
    r = '{v: rv, tag: c0_md[7:0], data: c0_data};
    rr_q.push_back(r);
    r = '{v: wv, tag: c1_md[7:0], data: '0};
    wr_q.push_back(r);
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_rd_cnt[i] = 0; m_wr_cnt[i] = 0; end
      m_rd_ptr = 0; m_wr_ptr = 0; m_err = 1'b0;
    end else begin
      if (gr >= 0) begin m_rd_cnt[gr]++; m_rd_ptr = (gr + 1) % N; end
      if (gw >= 0) begin m_wr_cnt[gw]++; m_wr_ptr = (gw + 1) % N; end
      if (rv != '0) m_rd_cnt[ir]--;
      if (wv != '0) m_wr_cnt[iw]--;
      m_err = m_err | bad_r | bad_w;
    end
    @(posedge clk); #1;
    e = c0_q.pop_front();
    check("c0_valid", c0_v_o, e.v);
    if (e.v) begin check("c0_addr", c0_addr_o, e.addr); check("c0_mdata", c0_md_o, e.md); end
    e = c1_q.pop_front();
    check("c1_valid", c1_v_o, e.v);
    if (e.v) begin
      check("c1_addr", c1_addr_o, e.addr); check("c1_mdata", c1_md_o, e.md); check("c1_data", c1_data_o, e.data);
    end
    r = rr_q.pop_front();
    check("rd_rsp_valid", rrsp_v, r.v);
    if (r.v != '0) begin check("rd_rsp_tag", rrsp_tag, r.tag); check("rd_rsp_data", rrsp_data, r.data); end
    r = wr_q.pop_front();
    check("wr_rsp_valid", wrsp_v, r.v);
    if (r.v != '0) check("wr_rsp_tag", wrsp_tag, r.tag);
    check("mux_error", err_o, m_err);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000};
    vecs[2]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0010, 4'b0000};
    vecs[6]  = '{4'b0000, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 4'b0100, 4'b0001};
    vecs[8]  = '{4'b0101, 4'b1010, 1'b0, 1'b0, 4'b0001, 4'b0010};
    vecs[9]  = '{4'b0000, 4'b1010, 1'b1, 1'b0, 4'b0000, 4'b1000};
    vecs[10] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000};
    vecs[11] = '{4'b1000, 4'b0110, 1'b0, 1'b0, 4'b1000, 4'b0010};

    for (int i = 0; i < N; i++) begin
      rd_addr[i] = AW'(42'h100 + i);  wr_addr[i] = AW'(42'h200 + i);
      rd_tag[i]  = TW'(8'hA0 + i);    wr_tag[i]  = TW'(8'hB0 + i);
      wr_data[i] = {16{32'hD000_0000 + 32'(i)}};
      m_rd_cnt[i] = 0; m_wr_cnt[i] = 0;
    end
    m_rd_ptr = 0; m_wr_ptr = 0; m_err = 1'b0;
    rd_v = '0; wr_v = '0; c0_af = 1'b0; c1_af = 1'b0;
    c0_rv = 1'b0; c1_rv = 1'b0; c0_md = '0; c1_md = '0; c0_data = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b0;

    // Round-robin, alm_full blocking and resume-at-pointer
    for (int v = 0; v < 12; v++) begin
      rd_v = vecs[v].rd; wr_v = vecs[v].wr; c0_af = vecs[v].af0; c1_af = vecs[v].af1;
      #1;
      check($sformatf("tbl%0d_rd_ready", v), rd_rdy, vecs[v].exp_rd);
      check($sformatf("tbl%0d_wr_ready", v), wr_rdy, vecs[v].exp_wr);
      tick();
    end
    rd_v = '0; wr_v = '0; c0_af = 1'b0; c1_af = 1'b0;
    tick();

    // Engine 2 fills its read credits; engine 1 still gets through
    reset = 1'b1; tick(); reset = 1'b0;
    rd_v = 4'b0100;
    repeat (64) tick();
    check("e2_cnt_full", dut.rd_cnt_q[2], 64);
    rd_v = 4'b0110;
    #1;
    check("e2_stalled", rd_rdy[2], 1'b0);
    check("e1_granted", rd_rdy[1], 1'b1);
    tick();
    rd_v = 4'b0100;
    tick();

    // Response for engine 2, tag 05
    rd_v = '0;
    c0_rv = 1'b1; c0_md = 16'h8005; c0_data = {16{32'hCAFE_0005}};
    tick();
    c0_rv = 1'b0;
    check("rsp_e2_valid", rrsp_v, 4'b0100);
    check("rsp_e2_tag", rrsp_tag, 8'h05);
    check("e2_cnt_dec", dut.rd_cnt_q[2], 63);

    // Reset mid-traffic, then a response with nothing outstanding
    rd_v = 4'b1111; wr_v = 4'b1111;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    rd_v = '0; wr_v = '0;
    tick();
    check("cnt_cleared", dut.rd_cnt_q[2], 0);
    c0_rv = 1'b1; c0_md = 16'h4001;
    tick();
    c0_rv = 1'b0;
    check("orphan_dropped", rrsp_v, 4'b0000);
    check("err_set", err_o, 1'b1);
    repeat (3) tick();
    check("err_sticky", err_o, 1'b1);

    // Grant and response for engine 0 in the same cycle at count 10
    reset = 1'b1; tick(); reset = 1'b0;
    rd_v = 4'b0001;
    repeat (10) tick();
    check("e0_cnt10", dut.rd_cnt_q[0], 10);
    c0_rv = 1'b1; c0_md = 16'h0003; c0_data = {16{32'h1234_5678}};
    tick();
    c0_rv = 1'b0; rd_v = '0;
    check("e0_cnt_hold", dut.rd_cnt_q[0], 10);
`ifdef CCI_MPF_ENGINE_MUX_STATS_EN
    check("e0_stat_rd", stat_rd[0], 32'd11);
`endif

    // Write path round trip for engine 3
    wr_v = 4'b1000;
    tick();
    wr_v = '0;
    tick();
    c1_rv = 1'b1; c1_md = 16'hC0B3;
    tick();
    c1_rv = 1'b0;
    check("wr_rsp_e3", wrsp_v, 4'b1000);
    check("wr_rsp_tag_e3", wrsp_tag, 8'hB3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
